// File: rtl/nerv_wb_bridge.sv
// nerv_wb_bridge: adapts nerv's one-cycle imem/dmem contract to two Wishbone
// buses (instruction and data), stalling the core while a bus cycle is open.
// Each core step runs CAPTURE -> BUS -> RELEASE. The core advances only in RELEASE.
// Optional: define NERV_WB_BRIDGE_TIMEOUT_EN to abort BUS after TIMEOUT_CYCLES
// cycles without both acknowledges.
module nerv_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    // nerv native ports
    input  logic [ADDR_WIDTH-1:0]   core_imem_addr_i,
    output logic [DATA_WIDTH-1:0]   core_imem_data_o,
    input  logic                    core_dmem_valid_i,
    input  logic [ADDR_WIDTH-1:0]   core_dmem_addr_i,
    input  logic [DATA_WIDTH/8-1:0] core_dmem_wstrb_i,
    input  logic [DATA_WIDTH-1:0]   core_dmem_wdata_i,
    output logic [DATA_WIDTH-1:0]   core_dmem_rdata_o,
    output logic                    core_stall_o,
    // instruction Wishbone bus
    output logic                    core_cyc,
    output logic                    core_stb,
    output logic                    core_we,
    output logic [DATA_WIDTH/8-1:0] core_sel,
    output logic [ADDR_WIDTH-1:0]   core_addr,
    output logic [DATA_WIDTH-1:0]   core_data_out,
    input  logic [DATA_WIDTH-1:0]   core_data_in,
    input  logic                    core_ack,
    // data Wishbone bus
    output logic                    data_mem_cyc,
    output logic                    data_mem_stb,
    output logic                    data_mem_we,
    output logic [DATA_WIDTH/8-1:0] data_mem_sel,
    output logic [ADDR_WIDTH-1:0]   data_mem_addr,
    output logic [DATA_WIDTH-1:0]   data_mem_data_out,
    input  logic [DATA_WIDTH-1:0]   data_mem_data_in,
    input  logic                    data_mem_ack,
    output logic                    bus_timeout_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        CAPTURE,
        BUS,
        RELEASE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   imem_addr_q;
    logic                    dmem_valid_q;
    logic [ADDR_WIDTH-1:0]   dmem_addr_q;
    logic [SEL_WIDTH-1:0]    dmem_wstrb_q;
    logic [DATA_WIDTH-1:0]   dmem_wdata_q;
    logic                    imem_done_q, dmem_done_q;
    logic [DATA_WIDTH-1:0]   imem_data_q, dmem_rdata_q;

    logic dmem_is_write;
    logic imem_ack_hit, dmem_ack_hit;
    logic imem_complete, dmem_complete;
    logic timeout_hit;

    assign dmem_is_write = |dmem_wstrb_q;
    // An ack only counts while the matching cyc is asserted.
    assign imem_ack_hit  = core_cyc & core_ack;
    assign dmem_ack_hit  = data_mem_cyc & data_mem_ack;
    assign imem_complete = imem_done_q | imem_ack_hit;
    assign dmem_complete = ~dmem_valid_q | dmem_done_q | dmem_ack_hit;

`ifdef NERV_WB_BRIDGE_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] NOP_INSN = DATA_WIDTH'(32'h0000_0013);

    logic [CNT_WIDTH-1:0] timeout_cnt_q;
    logic                 bus_timeout_q;

    // The last permitted BUS cycle is the one in which the count reads TIMEOUT_CYCLES-1.
    assign timeout_hit   = (state_q == BUS) && (timeout_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign bus_timeout_o = bus_timeout_q;

    // Timeout counter and sticky flag: cleared in CAPTURE, counts BUS cycles.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            timeout_cnt_q <= '0;
            bus_timeout_q <= 1'b0;
        end else begin
            if (state_q == CAPTURE) timeout_cnt_q <= '0;
            else if (state_q == BUS) timeout_cnt_q <= timeout_cnt_q + 1'b1;
            if (timeout_hit) bus_timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign bus_timeout_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_core) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_core) state_q <= CAPTURE;
        else          state_q <= state_d;
    end

    // Next-state logic: BUS ends when both required acks are in, or on timeout.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            CAPTURE: state_d = BUS;
            BUS:     if ((imem_complete && dmem_complete) || timeout_hit) state_d = RELEASE;
            RELEASE: state_d = CAPTURE;
            default: state_d = CAPTURE;
        endcase
    end

    // Output decode: each bus holds cyc/stb in BUS until its own ack has been seen.
    always_comb begin
        core_stall_o = (state_q != RELEASE);
        core_cyc     = 1'b0;
        data_mem_cyc = 1'b0;
        if (state_q == BUS) begin
            core_cyc     = ~imem_done_q;
            data_mem_cyc = dmem_valid_q & ~dmem_done_q;
        end
        core_stb     = core_cyc;
        data_mem_stb = data_mem_cyc;
        data_mem_we  = data_mem_cyc & dmem_is_write;
    end

    assign core_we           = 1'b0;
    assign core_sel          = '1;
    assign core_data_out     = '0;
    assign core_addr         = imem_addr_q;
    assign data_mem_addr     = dmem_addr_q;
    assign data_mem_data_out = dmem_wdata_q;
    assign data_mem_sel      = dmem_is_write ? dmem_wstrb_q : '1;
    assign core_imem_data_o  = imem_data_q;
    assign core_dmem_rdata_o = dmem_rdata_q;

    // Request capture, ack tracking and response latching.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            imem_addr_q  <= '0;
            dmem_valid_q <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wstrb_q <= '0;
            dmem_wdata_q <= '0;
            imem_done_q  <= 1'b0;
            dmem_done_q  <= 1'b0;
            imem_data_q  <= '0;
            dmem_rdata_q <= '0;
        end else begin
            if (state_q == CAPTURE) begin
                imem_addr_q  <= core_imem_addr_i;
                dmem_valid_q <= core_dmem_valid_i;
                dmem_addr_q  <= core_dmem_addr_i;
                dmem_wstrb_q <= core_dmem_wstrb_i;
                dmem_wdata_q <= core_dmem_wdata_i;
                imem_done_q  <= 1'b0;
                dmem_done_q  <= 1'b0;
            end else if (state_q == BUS) begin
                if (imem_ack_hit) begin
                    imem_done_q <= 1'b1;
                    imem_data_q <= core_data_in;
                end
                if (dmem_ack_hit) begin
                    dmem_done_q <= 1'b1;
                    if (!dmem_is_write) dmem_rdata_q <= data_mem_data_in;
                end
`ifdef NERV_WB_BRIDGE_TIMEOUT_EN
                // Abandoned transfers return a NOP fetch and a zero read.
                if (timeout_hit) begin
                    if (!imem_complete) imem_data_q <= NOP_INSN;
                    if (!dmem_complete && !dmem_is_write) dmem_rdata_q <= '0;
                end
`endif
            end
        end
    end

endmodule
